// File: rtl/fifo_drain_if.sv
// FIFO read port and downstream stream bundle for the length-controlled drain reader.
// master = drain controller, slave = FIFO/stream environment.
interface fifo_drain_if #(
    parameter int DATA_W = 8
);
    logic              fifo_empty_i;
    logic              fifo_rd_en_o;
    logic [DATA_W-1:0] fifo_data_i;
    logic              m_valid_o;
    logic [DATA_W-1:0] m_data_o;
    logic              m_ready_i;

    modport master (
        input  fifo_empty_i,
        input  fifo_data_i,
        input  m_ready_i,
        output fifo_rd_en_o,
        output m_valid_o,
        output m_data_o
    );

    modport slave (
        output fifo_empty_i,
        output fifo_data_i,
        output m_ready_i,
        input  fifo_rd_en_o,
        input  m_valid_o,
        input  m_data_o
    );
endinterface

// File: rtl/fifo_drain_ctrl.sv
// Pops len_i words from a registered-read FIFO and replays them on a valid/ready stream
// through a 3-entry skid buffer that hides the one-cycle read latency.
module fifo_drain_ctrl #(
    parameter int DATA_W = 8,
    parameter int LEN_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [LEN_W-1:0] len_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [LEN_W-1:0] rd_count_o,
    fifo_drain_if.master     bus
);
    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        FLUSH
    } state_t;

    state_t            state;
    logic [LEN_W-1:0]  remaining;
    logic [LEN_W-1:0]  rd_count;
    logic              inflight;
    logic              done;
    logic [DATA_W-1:0] buf_q [3];
    logic [1:0]        head;
    logic [1:0]        tail;
    logic [1:0]        occ;
    logic [2:0]        reserved;
    logic              rd_en;
    logic              push;
    logic              pop;

    // Reads in flight count against buffer space so a capture always has room.
    assign reserved = {1'b0, occ} + {2'b00, inflight};
    assign rd_en    = (state == DRAIN) && !bus.fifo_empty_i
                   && (remaining != '0) && (reserved < 3'd3);
    assign push     = inflight;
    assign pop      = (occ != 2'd0) && bus.m_ready_i;

    assign bus.fifo_rd_en_o = rd_en;
    assign bus.m_valid_o    = (occ != 2'd0);
    assign bus.m_data_o     = buf_q[head];
    assign busy_o           = (state != IDLE);
    assign done_o           = done;
    assign rd_count_o       = rd_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            remaining <= '0;
            rd_count  <= '0;
            inflight  <= 1'b0;
            done      <= 1'b0;
            head      <= 2'd0;
            tail      <= 2'd0;
            occ       <= 2'd0;
            for (int i = 0; i < 3; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            inflight <= rd_en;
            done     <= 1'b0;

            if (push) begin
                buf_q[tail] <= bus.fifo_data_i;
                tail        <= (tail == 2'd2) ? 2'd0 : tail + 2'd1;
            end
            if (pop) begin
                head <= (head == 2'd2) ? 2'd0 : head + 2'd1;
            end
            unique case ({push, pop})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase

            if (pop && (rd_count != {LEN_W{1'b1}})) begin
                rd_count <= rd_count + 1'b1;
            end

            unique case (state)
                IDLE: begin
                    if (start_i) begin
                        rd_count <= '0;
                        if (len_i != '0) begin
                            remaining <= len_i;
                            state     <= DRAIN;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (rd_en) begin
                        remaining <= remaining - 1'b1;
                        if (remaining == {{(LEN_W-1){1'b0}}, 1'b1}) begin
                            state <= FLUSH;
                        end
                    end
                end
                FLUSH: begin
                    if ((occ == 2'd0) && !inflight) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fifo_drain_ctrl.sv
// Directed bench for fifo_drain_ctrl with a registered-read FIFO model
// and a per-cycle stream collector.
module tb_fifo_drain_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_i = 1'b0;
    logic [7:0] len_i = 8'd0;
    logic       busy_o;
    logic       done_o;
    logic [7:0] rd_count_o;

    fifo_drain_if #(.DATA_W(8)) bus ();

    fifo_drain_ctrl #(.DATA_W(8), .LEN_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .len_i      (len_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .rd_count_o (rd_count_o),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [64];
    int wp = 0;
    int rp = 0;

    assign bus.fifo_empty_i = (wp == rp);

    always @(posedge clk) begin
        if (bus.fifo_rd_en_o) begin
            bus.fifo_data_i <= mem[rp[5:0]];
            rp <= rp + 1;
        end
    end

    int total = 0;
    int bad = 0;

    logic [7:0] got [$];
    int done_cnt, busy_cnt, rd_cnt, max_run;
    int v_empty, v_stable, v_occ;
    bit timed_out;
    int pat [4] = '{1, 0, 0, 1};

    task automatic push_word(input logic [7:0] v);
        mem[wp[5:0]] = v;
        wp = wp + 1;
    endtask

    task automatic collect(input int rep_at, input int push_at,
                           input logic [7:0] pv, input bit toggle);
        int iss, acc, run, after;
        bit stall;
        logic [7:0] hold;
        got.delete();
        done_cnt = 0; busy_cnt = 0; rd_cnt = 0; max_run = 0;
        v_empty = 0; v_stable = 0; v_occ = 0; timed_out = 1'b1;
        iss = 0; acc = 0; run = 0; after = 3; stall = 1'b0; hold = 8'h00;
        for (int c = 1; c <= 300; c++) begin
            @(posedge clk); #1;
            start_i = (c == rep_at);
            if (c == rep_at) len_i = 8'd2;
            if (c == push_at) begin
                push_word(pv);
                push_word(pv + 8'd1);
            end
            if (toggle) bus.m_ready_i = pat[c % 4][0];
            @(negedge clk);
            if (stall && (!bus.m_valid_o || bus.m_data_o !== hold)) v_stable++;
            if (iss - acc > 3) v_occ++;
            if (bus.fifo_rd_en_o) begin
                iss++; rd_cnt++; run++;
                if (bus.fifo_empty_i) v_empty++;
                if (run > max_run) max_run = run;
            end else begin
                run = 0;
            end
            if (bus.m_valid_o && bus.m_ready_i) begin
                got.push_back(bus.m_data_o);
                acc++;
            end
            stall = bus.m_valid_o && !bus.m_ready_i;
            hold = bus.m_data_o;
            if (busy_o) busy_cnt++;
            if (done_o) done_cnt++;
            if (done_cnt != 0) begin
                if (after == 0) begin
                    timed_out = 1'b0;
                    break;
                end
                after--;
            end
        end
    endtask

    task automatic start_xfer(input logic [7:0] n);
        @(posedge clk); #1;
        start_i = 1'b1;
        len_i = n;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", busy_o); end
        total++; if (done_o !== 1'b0) begin bad++; $display("FAIL rst_done got=%b want=0", done_o); end
        total++; if (bus.fifo_rd_en_o !== 1'b0) begin bad++; $display("FAIL rst_rd_en got=%b want=0", bus.fifo_rd_en_o); end
        total++; if (bus.m_valid_o !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", bus.m_valid_o); end
        total++; if (bus.m_data_o !== 8'h00) begin bad++; $display("FAIL rst_data got=%h want=00", bus.m_data_o); end
        total++; if (rd_count_o !== 8'd0) begin bad++; $display("FAIL rst_count got=%0d want=0", rd_count_o); end
        #1 rst = 1'b0;
    endtask

    task automatic test_full_rate;
        for (int i = 0; i < 8; i++) push_word(8'h10 + 8'(i));
        bus.m_ready_i = 1'b1;
        start_xfer(8'd8);
        collect(0, 0, 8'h00, 1'b0);
        total++; if (timed_out) begin bad++; $display("FAIL full_timeout got=timeout want=done"); end
        total++; if (got.size() !== 8) begin bad++; $display("FAIL full_beats got=%0d want=8", got.size()); end
        for (int i = 0; i < got.size() && i < 8; i++) begin
            total++;
            if (got[i] !== 8'h10 + 8'(i)) begin bad++; $display("FAIL full_data[%0d] got=%h want=%h", i, got[i], 8'h10 + 8'(i)); end
        end
        total++; if (max_run !== 8) begin bad++; $display("FAIL full_rd_run got=%0d want=8", max_run); end
        total++; if (done_cnt !== 1) begin bad++; $display("FAIL full_done got=%0d want=1", done_cnt); end
        total++; if (rd_count_o !== 8'd8) begin bad++; $display("FAIL full_count got=%0d want=8", rd_count_o); end
    endtask

    task automatic test_empty_stall;
        for (int i = 0; i < 3; i++) push_word(8'h20 + 8'(i));
        bus.m_ready_i = 1'b1;
        start_xfer(8'd5);
        collect(0, 10, 8'h23, 1'b0);
        total++; if (timed_out) begin bad++; $display("FAIL stall_timeout got=timeout want=done"); end
        total++; if (got.size() !== 5) begin bad++; $display("FAIL stall_beats got=%0d want=5", got.size()); end
        for (int i = 0; i < got.size() && i < 5; i++) begin
            total++;
            if (got[i] !== 8'h20 + 8'(i)) begin bad++; $display("FAIL stall_data[%0d] got=%h want=%h", i, got[i], 8'h20 + 8'(i)); end
        end
        total++; if (v_empty !== 0) begin bad++; $display("FAIL stall_rd_on_empty got=%0d want=0", v_empty); end
        total++; if (rd_cnt !== 5) begin bad++; $display("FAIL stall_reads got=%0d want=5", rd_cnt); end
        total++; if (done_cnt !== 1) begin bad++; $display("FAIL stall_done got=%0d want=1", done_cnt); end
    endtask

    task automatic test_backpressure;
        for (int i = 0; i < 8; i++) push_word(8'h30 + 8'(i));
        bus.m_ready_i = 1'b1;
        start_xfer(8'd8);
        collect(0, 0, 8'h00, 1'b1);
        bus.m_ready_i = 1'b1;
        total++; if (timed_out) begin bad++; $display("FAIL bp_timeout got=timeout want=done"); end
        total++; if (got.size() !== 8) begin bad++; $display("FAIL bp_beats got=%0d want=8", got.size()); end
        for (int i = 0; i < got.size() && i < 8; i++) begin
            total++;
            if (got[i] !== 8'h30 + 8'(i)) begin bad++; $display("FAIL bp_data[%0d] got=%h want=%h", i, got[i], 8'h30 + 8'(i)); end
        end
        total++; if (v_stable !== 0) begin bad++; $display("FAIL bp_stable got=%0d want=0", v_stable); end
        total++; if (v_occ !== 0) begin bad++; $display("FAIL bp_occupancy got=%0d want=0", v_occ); end
        total++; if (max_run >= 8) begin bad++; $display("FAIL bp_throttle got=%0d want=<8", max_run); end
        total++; if (rd_count_o !== 8'd8) begin bad++; $display("FAIL bp_count got=%0d want=8", rd_count_o); end
    endtask

    task automatic test_zero_len;
        push_word(8'h40);
        bus.m_ready_i = 1'b1;
        start_xfer(8'd0);
        collect(0, 0, 8'h00, 1'b0);
        total++; if (timed_out) begin bad++; $display("FAIL zero_timeout got=timeout want=done"); end
        total++; if (rd_cnt !== 0) begin bad++; $display("FAIL zero_reads got=%0d want=0", rd_cnt); end
        total++; if (done_cnt !== 1) begin bad++; $display("FAIL zero_done got=%0d want=1", done_cnt); end
        total++; if (busy_cnt !== 0) begin bad++; $display("FAIL zero_busy got=%0d want=0", busy_cnt); end
        total++; if (rd_count_o !== 8'd0) begin bad++; $display("FAIL zero_count got=%0d want=0", rd_count_o); end
        start_xfer(8'd1);
        collect(0, 0, 8'h00, 1'b0);
        total++; if (got.size() !== 1 || got[0] !== 8'h40) begin bad++; $display("FAIL zero_drain got=%0d beats want=1 beat of 40", got.size()); end
    endtask

    task automatic test_restart_ignored;
        for (int i = 0; i < 6; i++) push_word(8'h50 + 8'(i));
        bus.m_ready_i = 1'b1;
        start_xfer(8'd4);
        collect(2, 0, 8'h00, 1'b0);
        total++; if (timed_out) begin bad++; $display("FAIL restart_timeout got=timeout want=done"); end
        total++; if (got.size() !== 4) begin bad++; $display("FAIL restart_beats got=%0d want=4", got.size()); end
        for (int i = 0; i < got.size() && i < 4; i++) begin
            total++;
            if (got[i] !== 8'h50 + 8'(i)) begin bad++; $display("FAIL restart_data[%0d] got=%h want=%h", i, got[i], 8'h50 + 8'(i)); end
        end
        total++; if (done_cnt !== 1) begin bad++; $display("FAIL restart_done got=%0d want=1", done_cnt); end
        total++; if (rd_count_o !== 8'd4) begin bad++; $display("FAIL restart_count got=%0d want=4", rd_count_o); end
        start_xfer(8'd2);
        collect(0, 0, 8'h00, 1'b0);
        total++; if (got.size() !== 2 || got[0] !== 8'h54) begin bad++; $display("FAIL restart_leftover got=%0d beats want=2 from 54", got.size()); end
    endtask

    task automatic test_reset_midway;
        for (int i = 0; i < 8; i++) push_word(8'h60 + 8'(i));
        bus.m_ready_i = 1'b0;
        start_xfer(8'd8);
        @(posedge clk); #1;
        start_i = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++; if (bus.m_valid_o !== 1'b1 || busy_o !== 1'b1) begin bad++; $display("FAIL midrst_pre got=v%b b%b want=v1 b1", bus.m_valid_o, busy_o); end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        total++; if (bus.m_valid_o !== 1'b0) begin bad++; $display("FAIL midrst_valid got=%b want=0", bus.m_valid_o); end
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b want=0", busy_o); end
        total++; if (bus.fifo_rd_en_o !== 1'b0) begin bad++; $display("FAIL midrst_rd_en got=%b want=0", bus.fifo_rd_en_o); end
        bus.m_ready_i = 1'b1;
        start_xfer(8'd1);
        collect(0, 0, 8'h00, 1'b0);
        total++; if (timed_out) begin bad++; $display("FAIL midrst_timeout got=timeout want=done"); end
        total++; if (got.size() !== 1) begin bad++; $display("FAIL midrst_beats got=%0d want=1", got.size()); end
        if (got.size() == 1) begin
            total++;
            if (got[0] !== 8'h63) begin bad++; $display("FAIL midrst_data got=%h want=63", got[0]); end
        end
        total++; if (rd_count_o !== 8'd1) begin bad++; $display("FAIL midrst_count got=%0d want=1", rd_count_o); end
    endtask

    initial begin
        bus.m_ready_i = 1'b1;
        test_reset();
        test_full_rate();
        test_empty_stall();
        test_backpressure();
        test_zero_len();
        test_restart_ignored();
        test_reset_midway();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
